// File: rtl/fifo_reader.sv
// Drain-side reader for a registered-read FIFO: pops words, absorbs the one-cycle
// read latency in a 2-entry skid buffer, and presents them on a valid/ready stream.
// Optional delivered-word counter is enabled by defining FIFO_READER_COUNT_EN.
//
// state | meaning
// EMPTY | no buffered word, m_valid_o low
// ONE   | head holds the next word
// TWO   | head and tail both hold words, tail is the younger one
module fifo_reader #(
    parameter int width = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             fifo_empty_i,
    input  logic [width-1:0] fifo_dout_i,
    output logic             fifo_rd_en_o,
    output logic             m_valid_o,
    output logic [width-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic [31:0]      count_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e             state_q, state_d;
    logic             inflight_q;
    logic [width-1:0] head_q, head_d;
    logic [width-1:0] tail_q, tail_d;
    logic             pop;
    logic [1:0]       occ;
    logic [1:0]       level;

    assign occ       = state_q;
    assign m_valid_o = (state_q != EMPTY);
    assign m_data_o  = head_q;
    assign pop       = m_valid_o & m_ready_i;

    // Occupancy once this edge's pop and arrival are applied; bounded to 0..2
    // because a pop is only requested while this stays below 2.
    assign level = occ + {1'b0, inflight_q} - {1'b0, pop};

    assign fifo_rd_en_o = !fifo_empty_i && !reset_i && (level < 2'd2);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;

        case (level)
            2'd0:    state_d = EMPTY;
            2'd1:    state_d = ONE;
            default: state_d = TWO;
        endcase

        if (pop && (state_q == TWO)) begin
            head_d = tail_q;
        end

        if (inflight_q) begin
            if ((state_q == EMPTY) || ((state_q == ONE) && pop)) begin
                head_d = fifo_dout_i;
            end else begin
                tail_d = fifo_dout_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rd_en_o;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

`ifdef FIFO_READER_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (pop) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count_o = count_q;
`else
    assign count_o = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a behavioural registered-read FIFO feeds the DUT, a
// scoreboard queue holds expected words and a negedge monitor checks deliveries.
module tb_fifo_reader;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        fifo_empty_i;
    logic [7:0]  fifo_dout_i;
    logic        fifo_rd_en_o;
    logic        m_valid_o;
    logic [7:0]  m_data_o;
    logic        m_ready_i;
    logic [31:0] count_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] fmem [0:2047];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         pop_cnt = 0;
    logic [7:0] exp_q [$];

    fifo_reader #(.width(8)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_dout_i  (fifo_dout_i),
        .fifo_rd_en_o (fifo_rd_en_o),
        .m_valid_o    (m_valid_o),
        .m_data_o     (m_data_o),
        .m_ready_i    (m_ready_i),
        .count_o      (count_o)
    );

    always #5 clk_i = ~clk_i;

    assign fifo_empty_i = (wr_ptr == rd_ptr);

    initial fifo_dout_i = 8'h00;

    always @(posedge clk_i) begin
        if (fifo_rd_en_o) begin
            fifo_dout_i <= fmem[rd_ptr % 2048];
            rd_ptr      <= rd_ptr + 1;
            pop_cnt     <= pop_cnt + 1;
        end
    end

    task automatic push(input logic [7:0] w);
        fmem[wr_ptr % 2048] = w;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor, stall-stability and empty-pop checks.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk_i) begin
        if (!reset_i) begin
            checks++;
            if (fifo_rd_en_o && fifo_empty_i) begin
                errors++;
                $display("FAIL rd_en_while_empty: rd_en=%0b empty=%0b", fifo_rd_en_o, fifo_empty_i);
            end
            if (prev_stall) begin
                checks++;
                if (!m_valid_o || m_data_o !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%0b data=%0h, expected valid=1 data=%0h",
                             m_valid_o, m_data_o, prev_data);
                end
            end
            if (m_valid_o && m_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_extra: got %0h, expected no word", m_data_o);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (m_data_o !== e) begin
                        errors++;
                        $display("FAIL scoreboard_data: got %0h, expected %0h", m_data_o, e);
                    end
                end
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_data  = m_data_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

`ifdef FIFO_READER_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic drain(input int budget, input bit random_ready);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            if (random_ready) m_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
        end
        m_ready_i = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        int p0;

        // Reset and idle
        reset_i   = 1'b1;
        m_ready_i = 1'b0;
        tick();
        @(negedge clk_i);
        chk("reset_valid", 32'(m_valid_o), 32'd0);
        chk("reset_data", 32'(m_data_o), 32'd0);
        chk("reset_rd_en", 32'(fifo_rd_en_o), 32'd0);
        chk("reset_count", count_o, 32'd0);
        tick();
        reset_i   = 1'b0;
        m_ready_i = 1'b1;
        repeat (2) tick();

        // Single word: visible exactly two cycles after empty falls, for one cycle
        push(8'hA5);
        @(negedge clk_i);
        chk("single_rd_en_c0", 32'(fifo_rd_en_o), 32'd1);
        chk("single_valid_c0", 32'(m_valid_o), 32'd0);
        tick();
        @(negedge clk_i);
        chk("single_valid_c1", 32'(m_valid_o), 32'd0);
        tick();
        @(negedge clk_i);
        chk("single_valid_c2", 32'(m_valid_o), 32'd1);
        chk("single_data_c2", 32'(m_data_o), 32'hA5);
        tick();
        @(negedge clk_i);
        chk("single_valid_c3", 32'(m_valid_o), 32'd0);
        chk("single_count", count_o, CNT_EN ? 32'd1 : 32'd0);
        repeat (2) tick();

        // Streaming: eight consecutive valid cycles starting at cycle 2
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (2) tick();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            chk("stream_valid", 32'(m_valid_o), 32'd1);
            tick();
        end
        @(negedge clk_i);
        chk("stream_valid_end", 32'(m_valid_o), 32'd0);
        repeat (2) tick();

        // Back-pressure: two pops then hold, then drain on consecutive cycles
        m_ready_i = 1'b0;
        p0 = pop_cnt;
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        repeat (6) tick();
        @(negedge clk_i);
        chk("bp_pops", 32'(pop_cnt - p0), 32'd2);
        chk("bp_rd_en_held", 32'(fifo_rd_en_o), 32'd0);
        chk("bp_head", 32'(m_data_o), 32'h10);
        tick();
        m_ready_i = 1'b1;
        @(negedge clk_i);
        chk("bp_rd_en_release", 32'(fifo_rd_en_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk_i);
            chk("bp_release_valid", 32'(m_valid_o), 32'd1);
            chk("bp_release_data", 32'(m_data_o), 32'h10 + 32'(i));
            tick();
        end
        drain(50, 1'b0);

        // Reset mid-operation: pop with occ=2, reset the next cycle
        m_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
        repeat (3) tick();
        m_ready_i = 1'b1;
        @(negedge clk_i);
        chk("mid_rd_en_occ2_pop", 32'(fifo_rd_en_o), 32'd1);
        tick();
        reset_i   = 1'b1;
        m_ready_i = 1'b0;
        // 0x21 buffered and 0x22 in flight are discarded by reset
        exp_q.delete();
        exp_q.push_back(8'h23);
        exp_q.push_back(8'h24);
        exp_q.push_back(8'h25);
        @(negedge clk_i);
        chk("mid_rd_en_in_reset", 32'(fifo_rd_en_o), 32'd0);
        tick();
        reset_i   = 1'b0;
        m_ready_i = 1'b1;
        @(negedge clk_i);
        chk("mid_valid_after_reset", 32'(m_valid_o), 32'd0);
        chk("mid_rd_en_first_cycle", 32'(fifo_rd_en_o), 32'd1);
        drain(50, 1'b0);
        chk("mid_count", count_o, CNT_EN ? 32'd3 : 32'd0);

        // Random back-pressure over 1000 words from a fresh reset
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        for (int i = 0; i < 1000; i++) push(8'((i * 7 + 3) & 255));
        drain(20000, 1'b1);
        chk("random_count", count_o, CNT_EN ? 32'd1000 : 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
